// File: rtl/uart_cmd_framer_if.sv
// Receiver-side byte strobe and ALU-side command handshake of the command framer.
interface uart_cmd_framer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] opcode;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       timeout_err;
  logic       overrun_err;
  logic       busy;

  // Framer view: consumes bytes and ready, produces the command and status.
  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, opcode, operand_a, operand_b, timeout_err, overrun_err, busy
  );

  // Environment view: feeds bytes and ready, observes the command and status.
  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, opcode, operand_a, operand_b, timeout_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// Assembles opcode/operand A/operand B bytes from the UART receiver into one
// command, holds it for the ALU until accepted, and drops stalled frames.
module uart_cmd_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 208333,
  parameter int unsigned CNT_W          = 18
) (
  input  logic             clk,
  input  logic             rst,
  uart_cmd_framer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GOT_OP, GOT_A, HOLD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [7:0]       operand_a_q, operand_a_d;
  logic [7:0]       operand_b_q, operand_b_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic             overrun_err_q, overrun_err_d;
  logic             busy_q, busy_d;
  logic             handshake;

  assign handshake = cmd_valid_q && bus.cmd_ready;

  // Next-state, field capture, inter-byte timer and error pulses.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    opcode_d      = opcode_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          opcode_d = bus.rx_data[7:5];
          state_d  = GOT_OP;
        end
      end
      GOT_OP, GOT_A: begin
        // An arriving byte beats an expiring timer.
        if (bus.rx_valid) begin
          if (state_q == GOT_OP) begin
            operand_a_d = bus.rx_data;
            state_d     = GOT_A;
          end else begin
            operand_b_d = bus.rx_data;
            state_d     = HOLD;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        // A byte coinciding with the handshake starts the next frame.
        if (handshake) begin
          if (bus.rx_valid) begin
            opcode_d = bus.rx_data[7:5];
            state_d  = GOT_OP;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.rx_valid) begin
          overrun_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      opcode_q      <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      cmd_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      opcode_q      <= opcode_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      cmd_valid_q   <= cmd_valid_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand_a   = operand_a_q;
  assign bus.operand_b   = operand_b_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign bus.busy        = busy_q;

endmodule
